// File: rtl/matmul_stream_sequencer.sv
// matmul_stream_sequencer: feeds A/B stream words into a banked matmul accelerator over Avalon-MM,
// polls for completion, then reads C back out as a one-entry buffered stream.
module matmul_stream_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int M = 3,
  parameter int K = 3,
  parameter int N = 3,
  parameter int N_BANKS = 3,
  parameter int POLL_LIMIT = 1024,
  localparam int W = N_BANKS * DATA_WIDTH,
  localparam int ACC_W = 2 * DATA_WIDTH + ((K <= 1) ? 1 : $clog2(K))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             snk_valid,
  output logic             snk_ready,
  input  logic [W-1:0]     snk_data,
  output logic             src_valid,
  input  logic             src_ready,
  output logic [ACC_W-1:0] src_data,
  output logic             src_last,
  output logic [2:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [W-1:0]     avm_writedata,
  output logic [W/8-1:0]   avm_byteenable,
  input  logic [W-1:0]     avm_readdata,
  input  logic             avm_waitrequest
);
  localparam int A_WORDS = (M / N_BANKS) * K;
  localparam int B_WORDS = K * (N / N_BANKS);
  localparam int C_WORDS = M * N;
  localparam int MAX_AB = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
  localparam int MAX_CP = (C_WORDS > POLL_LIMIT) ? C_WORDS : POLL_LIMIT;
  localparam int CNT_MAX = (MAX_AB > MAX_CP) ? MAX_AB : MAX_CP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, RST_ASSERT, RST_RELEASE, A_ADDR, A_DATA, B_ADDR, B_DATA, START,
    POLL, POLL_WAIT, C_ADDR, C_READ, C_WAIT, C_PUSH, FINISH, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic [ACC_W-1:0] src_data_q, src_data_d;
  logic             acc;

  assign acc = !avm_waitrequest;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign error = error_q;
  assign src_valid = state_q == C_PUSH;
  assign src_last = src_valid && cnt_q == CNT_W'(C_WORDS - 1);
  assign src_data = src_data_q;
  assign avm_byteenable = '1;

  // One counter serves A/B/C word indices and the poll count; each phase restarts it at zero.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    error_d = error_q;
    src_data_d = src_data_q;
    avm_address = '0;
    avm_read = 1'b0;
    avm_write = 1'b0;
    avm_writedata = '0;
    snk_ready = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = RST_ASSERT;
        cnt_d = '0;
        error_d = 1'b0;
      end
      RST_ASSERT: begin
        avm_write = 1'b1;
        state_d = acc ? RST_RELEASE : state_q;
      end
      RST_RELEASE: begin
        avm_write = 1'b1;
        avm_writedata = W'(2);
        state_d = acc ? A_ADDR : state_q;
        cnt_d = '0;
      end
      A_ADDR, B_ADDR: begin
        avm_address = (state_q == A_ADDR) ? 3'd4 : 3'd6;
        avm_write = 1'b1;
        avm_writedata = W'(cnt_q);
        state_d = acc ? ((state_q == A_ADDR) ? A_DATA : B_DATA) : state_q;
      end
      A_DATA: begin
        avm_address = 3'd5;
        avm_write = snk_valid;
        avm_writedata = snk_data;
        snk_ready = snk_valid && acc;
        if (snk_ready) begin
          state_d = (cnt_q == CNT_W'(A_WORDS - 1)) ? B_ADDR : A_ADDR;
          cnt_d = (cnt_q == CNT_W'(A_WORDS - 1)) ? '0 : cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        avm_address = 3'd7;
        avm_write = snk_valid;
        avm_writedata = snk_data;
        snk_ready = snk_valid && acc;
        if (snk_ready) begin
          state_d = (cnt_q == CNT_W'(B_WORDS - 1)) ? START : B_ADDR;
          cnt_d = (cnt_q == CNT_W'(B_WORDS - 1)) ? '0 : cnt_q + 1'b1;
        end
      end
      START: begin
        avm_write = 1'b1;
        avm_writedata = W'(3);
        state_d = acc ? POLL : state_q;
      end
      POLL: begin
        avm_address = 3'd1;
        avm_read = 1'b1;
        state_d = acc ? POLL_WAIT : state_q;
      end
      POLL_WAIT: if (avm_readdata[0]) begin
        state_d = C_ADDR;
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
        state_d = ERROR;
        error_d = 1'b1;
      end else begin
        state_d = POLL;
        cnt_d = cnt_q + 1'b1;
      end
      C_ADDR: begin
        avm_address = 3'd2;
        avm_write = 1'b1;
        avm_writedata = W'(cnt_q);
        state_d = acc ? C_READ : state_q;
      end
      C_READ: begin
        avm_address = 3'd3;
        avm_read = 1'b1;
        state_d = acc ? C_WAIT : state_q;
      end
      C_WAIT: begin
        src_data_d = ACC_W'(avm_readdata);
        state_d = C_PUSH;
      end
      C_PUSH: if (src_ready) begin
        state_d = src_last ? FINISH : C_ADDR;
        cnt_d = src_last ? cnt_q : cnt_q + 1'b1;
      end
      FINISH: state_d = IDLE;
      ERROR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      error_q <= 1'b0;
      src_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      error_q <= error_d;
      src_data_q <= src_data_d;
    end
  end
endmodule
